// File: rtl/adc_snapshot_buffer.sv
// Triggered snapshot buffer for one ADC lane: arm, wait for trigger, capture a burst
// of words, then drain them one at a time on a registered valid/ready stream.
module adc_snapshot_buffer #(
  parameter int DATA_W = 128,
  parameter int DEPTH  = 16,
  parameter int LEN_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              trig,
  input  logic [LEN_W-1:0]  cap_len,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        state_out,
  output logic [LEN_W-1:0]  words_left,
  output logic [31:0]       trig_delay,
  output logic              done
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  state_t            state_r, state_s;
  logic [PTR_W-1:0]  wr_ptr_r, wr_ptr_s;
  logic [PTR_W-1:0]  rd_ptr_r, rd_ptr_s;
  logic [LEN_W-1:0]  len_r, len_s;
  logic [LEN_W-1:0]  words_left_r, words_left_s;
  logic [31:0]       trig_delay_r, trig_delay_s;
  logic              out_valid_r, out_valid_s;
  logic [DATA_W-1:0] out_data_r, out_data_s;
  logic              done_r, done_s;
  logic              we_s;
  logic [LEN_W-1:0]  len_clamped_s;
  logic [PTR_W-1:0]  rd_ptr_inc_s;
  logic [DATA_W-1:0] mem_r [DEPTH];

  // Next-state, pointer and output-register logic.
  always_comb begin
    state_s       = state_r;
    wr_ptr_s      = wr_ptr_r;
    rd_ptr_s      = rd_ptr_r;
    len_s         = len_r;
    words_left_s  = words_left_r;
    trig_delay_s  = trig_delay_r;
    out_valid_s   = out_valid_r;
    out_data_s    = out_data_r;
    done_s        = 1'b0;
    we_s          = 1'b0;
    rd_ptr_inc_s  = rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};

    if ((cap_len == {LEN_W{1'b0}}) || (cap_len > LEN_W'(DEPTH))) begin
      len_clamped_s = LEN_W'(DEPTH);
    end else begin
      len_clamped_s = cap_len;
    end

    if (arm) begin
      state_s      = ARMED;
      len_s        = len_clamped_s;
      wr_ptr_s     = {PTR_W{1'b0}};
      rd_ptr_s     = {PTR_W{1'b0}};
      words_left_s = {LEN_W{1'b0}};
      trig_delay_s = 32'd0;
      out_valid_s  = 1'b0;
      out_data_s   = {DATA_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          state_s = IDLE;
        end
        ARMED: begin
          if (trig_delay_r != 32'hFFFF_FFFF) begin
            trig_delay_s = trig_delay_r + 32'd1;
          end else begin
            trig_delay_s = trig_delay_r;
          end
          if (trig) begin
            state_s = CAPTURE;
            we_s    = s_valid;
          end else begin
            state_s = ARMED;
          end
        end
        CAPTURE: begin
          we_s = s_valid;
        end
        DRAIN: begin
          if (out_ready && out_valid_r) begin
            rd_ptr_s     = rd_ptr_inc_s;
            words_left_s = words_left_r - LEN_W'(1);
            if (words_left_r == LEN_W'(1)) begin
              done_s      = 1'b1;
              state_s     = IDLE;
              out_valid_s = 1'b0;
            end else begin
              out_data_s = mem_r[rd_ptr_inc_s];
            end
          end else begin
            state_s = DRAIN;
          end
        end
        default: begin
          state_s = IDLE;
        end
      endcase

      // Final write preloads word 0; forward s_data when it is that word.
      if (we_s) begin
        wr_ptr_s     = wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
        words_left_s = words_left_r + LEN_W'(1);
        if ((words_left_r + LEN_W'(1)) == len_r) begin
          state_s     = DRAIN;
          out_valid_s = 1'b1;
          if (wr_ptr_r == rd_ptr_r) begin
            out_data_s = s_data;
          end else begin
            out_data_s = mem_r[rd_ptr_r];
          end
        end else begin
          out_valid_s = 1'b0;
        end
      end else begin
        we_s = 1'b0;
      end
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= IDLE;
      wr_ptr_r     <= {PTR_W{1'b0}};
      rd_ptr_r     <= {PTR_W{1'b0}};
      len_r        <= {LEN_W{1'b0}};
      words_left_r <= {LEN_W{1'b0}};
      trig_delay_r <= 32'd0;
      out_valid_r  <= 1'b0;
      out_data_r   <= {DATA_W{1'b0}};
      done_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      wr_ptr_r     <= wr_ptr_s;
      rd_ptr_r     <= rd_ptr_s;
      len_r        <= len_s;
      words_left_r <= words_left_s;
      trig_delay_r <= trig_delay_s;
      out_valid_r  <= out_valid_s;
      out_data_r   <= out_data_s;
      done_r       <= done_s;
    end
  end

  // Capture storage; contents need no reset.
  always_ff @(posedge clk) begin
    if (we_s) begin
      mem_r[wr_ptr_r] <= s_data;
    end
  end

  assign out_data   = out_data_r;
  assign out_valid  = out_valid_r;
  assign state_out  = state_r;
  assign words_left = words_left_r;
  assign trig_delay = trig_delay_r;
  assign done       = done_r;

endmodule

// File: tb/tb_adc_snapshot_buffer.sv
// Directed self-checking bench for adc_snapshot_buffer with a scoreboard queue of
// captured words that is drained against the DUT output stream.
module tb_adc_snapshot_buffer;

  localparam int DATA_W = 128;
  localparam int LEN_W  = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              arm, trig, s_valid, out_ready;
  logic [LEN_W-1:0]  cap_len;
  logic [DATA_W-1:0] s_data;
  logic [DATA_W-1:0] out_data;
  logic              out_valid, done;
  logic [1:0]        state_out;
  logic [LEN_W-1:0]  words_left;
  logic [31:0]       trig_delay;

  int total = 0;
  int bad   = 0;
  logic [DATA_W-1:0] sb[$];

  adc_snapshot_buffer dut (
    .clk(clk), .rst(rst), .arm(arm), .trig(trig), .cap_len(cap_len),
    .s_data(s_data), .s_valid(s_valid), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .state_out(state_out), .words_left(words_left),
    .trig_delay(trig_delay), .done(done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] mk(input int tag, input int idx);
    return {32'(tag), 32'(idx), $urandom, $urandom};
  endfunction

  task automatic push_word(input logic [DATA_W-1:0] w);
    s_data  = w;
    s_valid = 1'b1;
    sb.push_back(w);
    step();
    s_valid = 1'b0;
  endtask

  task automatic pop_one(input string tag);
    logic [DATA_W-1:0] exp;
    exp = sb.pop_front();
    chk({tag, "_valid"}, DATA_W'(out_valid), DATA_W'(1'b1));
    chk({tag, "_data"}, out_data, exp);
    chk({tag, "_nodone"}, DATA_W'(done), DATA_W'(1'b0));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic chk_end(input string tag);
    chk({tag, "_done"}, DATA_W'(done), DATA_W'(1'b1));
    chk({tag, "_state"}, DATA_W'(state_out), DATA_W'(2'd0));
    chk({tag, "_valid"}, DATA_W'(out_valid), DATA_W'(1'b0));
    chk({tag, "_wl"}, DATA_W'(words_left), DATA_W'(0));
  endtask

  initial begin
    rst = 1'b0; arm = 1'b0; trig = 1'b0; s_valid = 1'b0; out_ready = 1'b0;
    cap_len = '0; s_data = '0;
    step(); step();
    chk("rst_state", DATA_W'(state_out), DATA_W'(2'd0));
    chk("rst_valid", DATA_W'(out_valid), DATA_W'(1'b0));
    chk("rst_data", out_data, '0);
    chk("rst_wl", DATA_W'(words_left), DATA_W'(0));
    chk("rst_delay", DATA_W'(trig_delay), DATA_W'(0));
    rst = 1'b1;
    step();

    // Basic burst: len 4, trigger 10 cycles after arm.
    cap_len = 5'd4; arm = 1'b1; step(); arm = 1'b0;
    chk("a_armed", DATA_W'(state_out), DATA_W'(2'd1));
    repeat (9) step();
    trig = 1'b1; step(); trig = 1'b0;
    chk("a_capture", DATA_W'(state_out), DATA_W'(2'd2));
    chk("a_delay", DATA_W'(trig_delay), DATA_W'(10));
    for (int i = 0; i < 4; i++) push_word(mk(32'hA0, i));
    chk("a_drain", DATA_W'(state_out), DATA_W'(2'd3));
    chk("a_wl", DATA_W'(words_left), DATA_W'(4));
    chk("a_delay_hold", DATA_W'(trig_delay), DATA_W'(10));
    for (int i = 0; i < 4; i++) pop_one("a_pop");
    chk_end("a_end");
    step();
    chk("a_done_pulse", DATA_W'(done), DATA_W'(1'b0));

    // arm together with trig from IDLE: only arms.
    cap_len = 5'd2; arm = 1'b1; trig = 1'b1; s_valid = 1'b1; s_data = mk(32'hEE, 0);
    step();
    arm = 1'b0; trig = 1'b0; s_valid = 1'b0;
    chk("at_state", DATA_W'(state_out), DATA_W'(2'd1));
    chk("at_wl", DATA_W'(words_left), DATA_W'(0));

    // Re-arm with len 1: trig with s_valid captures word 0 and drains at once.
    cap_len = 5'd1; arm = 1'b1; step(); arm = 1'b0;
    trig = 1'b1; push_word(mk(32'hB1, 0)); trig = 1'b0;
    chk("l1_drain", DATA_W'(state_out), DATA_W'(2'd3));
    chk("l1_wl", DATA_W'(words_left), DATA_W'(1));
    pop_one("l1_pop");
    chk_end("l1_end");

    // len 0 clamps to 16; trig word is word 0; extra s_valid in DRAIN ignored.
    cap_len = 5'd0; arm = 1'b1; step(); arm = 1'b0;
    trig = 1'b1; push_word(mk(32'hC0, 0)); trig = 1'b0;
    chk("c_capture", DATA_W'(state_out), DATA_W'(2'd2));
    for (int i = 1; i < 16; i++) push_word(mk(32'hC0, i));
    chk("c_drain", DATA_W'(state_out), DATA_W'(2'd3));
    chk("c_wl16", DATA_W'(words_left), DATA_W'(16));
    s_data = mk(32'hDD, 0); s_valid = 1'b1; step(); s_valid = 1'b0;
    chk("c_ign_wl", DATA_W'(words_left), DATA_W'(16));
    chk("c_ign_data", out_data, sb[0]);
    for (int i = 0; i < 16; i++) begin
      chk("c_wl_count", DATA_W'(words_left), DATA_W'(16 - i));
      pop_one("c_pop");
    end
    chk_end("c_end");

    // Gappy s_valid pattern 1,0,0,1,1 with len 3.
    cap_len = 5'd3; arm = 1'b1; step(); arm = 1'b0;
    trig = 1'b1; step(); trig = 1'b0;
    begin
      logic [4:0] pat;
      pat = 5'b11001;
      for (int i = 0; i < 5; i++) begin
        if (pat[i]) push_word(mk(32'hD0, i));
        else begin
          s_data = mk(32'hBAD, i);
          step();
        end
      end
    end
    chk("g_drain", DATA_W'(state_out), DATA_W'(2'd3));
    chk("g_wl", DATA_W'(words_left), DATA_W'(3));
    for (int i = 0; i < 3; i++) pop_one("g_pop");
    chk_end("g_end");

    // Abort mid-DRAIN after 2 of 5 pops; arm beats a simultaneous pop.
    cap_len = 5'd5; arm = 1'b1; step(); arm = 1'b0;
    trig = 1'b1; step(); trig = 1'b0;
    for (int i = 0; i < 5; i++) push_word(mk(32'hE0, i));
    pop_one("ab_pop");
    pop_one("ab_pop");
    cap_len = 5'd3; arm = 1'b1; out_ready = 1'b1; step(); arm = 1'b0; out_ready = 1'b0;
    sb.delete();
    chk("ab_valid", DATA_W'(out_valid), DATA_W'(1'b0));
    chk("ab_state", DATA_W'(state_out), DATA_W'(2'd1));
    chk("ab_done", DATA_W'(done), DATA_W'(1'b0));
    chk("ab_wl", DATA_W'(words_left), DATA_W'(0));
    chk("ab_delay", DATA_W'(trig_delay), DATA_W'(0));

    // Async reset between edges while capturing.
    trig = 1'b1; push_word(mk(32'hF0, 0)); trig = 1'b0;
    push_word(mk(32'hF0, 1));
    chk("r_capture", DATA_W'(state_out), DATA_W'(2'd2));
    chk("r_wl_pre", DATA_W'(words_left), DATA_W'(2));
    #2 rst = 1'b0;
    #1;
    chk("r_state", DATA_W'(state_out), DATA_W'(2'd0));
    chk("r_wl", DATA_W'(words_left), DATA_W'(0));
    chk("r_delay", DATA_W'(trig_delay), DATA_W'(0));
    chk("r_valid", DATA_W'(out_valid), DATA_W'(1'b0));
    chk("r_data", out_data, '0);
    chk("r_done", DATA_W'(done), DATA_W'(1'b0));
    sb.delete();
    step();
    rst = 1'b1;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
